cache_mem_arbiter: RTL and testbench

Shares the single pipelined main memory between the I-cache fill path and the D-cache fill/write-through path. Each granted cache miss becomes an 8-word block refill; each D-cache store becomes a single-word memory write. The block sits between the two cache controllers and the memory module, and it owns `icache_req`/`dcache_req` sequencing during misses.

---
 rtl/cache_mem_arbiter_pkg.sv | 17 +
 rtl/cache_mem_arbiter_if.sv | 46 ++++
 rtl/block_fill_seq.sv | 91 +++++++++
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and constants for the cache/memory arbiter
// Contents: arb_state_t FSM encoding, block geometry, block base mask, memory latency.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } arb_state_t;

    localparam int          BLOCK_WORDS       = 8;
    localparam int          WORD_IDX_W        = 3;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
    localparam int          MEM_LAT           = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side signal bundle of the arbiter
// slave  : arbiter view (requests and mem_data_* in; fills, acks and mem_* commands out)
// master : environment view (cache controllers and memory), directions reversed
interface cache_mem_arbiter_if
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic                  icache_miss;
    logic [ADDR_W-1:0]     icache_miss_addr;
    logic                  dcache_miss;
    logic [ADDR_W-1:0]     dcache_miss_addr;
    logic                  dcache_wr_req;
    logic [ADDR_W-1:0]     dcache_wr_addr;
    logic [DATA_W-1:0]     dcache_wr_data;
    logic                  fill_we;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [DATA_W-1:0]     fill_data;
    logic                  fill_to_dcache;
    logic                  icache_fill_done;
    logic                  dcache_fill_done;
    logic                  dcache_wr_ack;
    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     mem_data_out;
    logic                  mem_data_valid;

    modport slave (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        output fill_we, fill_word, fill_data, fill_to_dcache, icache_fill_done,
               dcache_fill_done, dcache_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        input  fill_we, fill_word, fill_data, fill_to_dcache, icache_fill_done,
               dcache_fill_done, dcache_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/block_fill_seq.sv
// rtl/block_fill_seq.sv - issue/return sequencer for one 8-word block refill
// In : clk, rst, start_i (load base, begin fill), base_i, mem_valid_i, mem_data_i
// Out: issue_en_o/issue_addr_o (read command), fill_we_o/fill_word_o/fill_data_o, done_o
module block_fill_seq
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic                  issue_en_o,
    output logic [ADDR_W-1:0]     issue_addr_o,
    output logic                  fill_we_o,
    output logic [WORD_IDX_W-1:0] fill_word_o,
    output logic [DATA_W-1:0]     fill_data_o,
    output logic                  done_o
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    logic [ADDR_W-1:0]     base_q, base_d;
    logic [WORD_IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_W-1:0] ret_cnt_q, ret_cnt_d;
    logic                  issuing_q, issuing_d;
    logic                  active_q, active_d;
    logic                  fill_we;
    logic                  done;

    // Returns are accepted only while a fill is live, so stray or pre-reset
    // data never reaches a cache.
    assign fill_we = active_q & mem_valid_i;
    assign done    = fill_we & (ret_cnt_q == LAST_WORD);

    always_comb begin
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        issuing_d   = issuing_q;
        active_d    = active_q;
        if (start_i) begin
            base_d      = base_i;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            issuing_d   = 1'b1;
            active_d    = 1'b1;
        end else begin
            if (issuing_q) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_WORD) begin
                    issuing_d = 1'b0;
                end
            end
            if (fill_we) begin
                ret_cnt_d = ret_cnt_q + 1'b1;
                if (done) begin
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            issuing_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            issuing_q   <= issuing_d;
            active_q    <= active_d;
        end
    end

    // Word stride is 2 bytes; the sum wraps naturally at ADDR_W bits.
    assign issue_addr_o = base_q + ADDR_W'({issue_cnt_q, 1'b0});
    assign issue_en_o   = issuing_q;
    assign fill_we_o    = fill_we;
    assign fill_word_o  = ret_cnt_q;
    assign fill_data_o  = mem_data_i;
    assign done_o       = done;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares main memory between I-cache fills and D-cache fills/stores
// Ports: clk, rst (async, active-high), bus (cache_mem_arbiter_if.slave)
// Build option: ARB_ROUND_ROBIN_EN alternates D/I miss grants; stores always win.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_arbiter_if.slave    bus
);

    // Clears the byte offset within a block for any ADDR_W >= 4.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLOCK_OFFSET_MASK);

    arb_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic                  seq_start;
    logic [ADDR_W-1:0]     seq_base;
    logic                  seq_issue_en;
    logic [ADDR_W-1:0]     seq_issue_addr;
    logic                  seq_we;
    logic [WORD_IDX_W-1:0] seq_word;
    logic [DATA_W-1:0]     seq_data;
    logic                  seq_done;
    logic                  take_d;

    logic                  mem_enable, mem_wr, wr_ack;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data_in;
    logic                  fill_we, to_dcache, i_done, d_done;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [DATA_W-1:0]     fill_data;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent fill grant went to the D-cache.
    logic last_d_q, last_d_d;

    assign take_d   = bus.dcache_miss & (~bus.icache_miss | ~last_d_q);
    assign last_d_d = seq_start ? (state_d == FILL_D) : last_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign take_d = bus.dcache_miss;
`endif

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        seq_start   = 1'b0;
        seq_base    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        wr_ack      = 1'b0;
        fill_we     = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        to_dcache   = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dcache_wr_req) begin
                    state_d   = WRITE;
                    wr_addr_d = bus.dcache_wr_addr;
                    wr_data_d = bus.dcache_wr_data;
                end else if (take_d) begin
                    state_d   = FILL_D;
                    seq_start = 1'b1;
                    seq_base  = bus.dcache_miss_addr & BASE_MASK;
                end else if (bus.icache_miss) begin
                    state_d   = FILL_I;
                    seq_start = 1'b1;
                    seq_base  = bus.icache_miss_addr & BASE_MASK;
                end
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = wr_addr_q;
                mem_data_in = wr_data_q;
                wr_ack      = 1'b1;
                state_d     = IDLE;
            end
            FILL_I, FILL_D: begin
                to_dcache  = (state_q == FILL_D);
                mem_enable = seq_issue_en;
                mem_addr   = seq_issue_en ? seq_issue_addr : '0;
                fill_we    = seq_we;
                fill_word  = seq_word;
                fill_data  = seq_we ? seq_data : '0;
                i_done     = seq_done & ~to_dcache;
                d_done     = seq_done & to_dcache;
                if (seq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    block_fill_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (seq_start),
        .base_i       (seq_base),
        .mem_valid_i  (bus.mem_data_valid),
        .mem_data_i   (bus.mem_data_out),
        .issue_en_o   (seq_issue_en),
        .issue_addr_o (seq_issue_addr),
        .fill_we_o    (seq_we),
        .fill_word_o  (seq_word),
        .fill_data_o  (seq_data),
        .done_o       (seq_done)
    );

    assign bus.mem_enable       = mem_enable;
    assign bus.mem_wr           = mem_wr;
    assign bus.mem_addr         = mem_addr;
    assign bus.mem_data_in      = mem_data_in;
    assign bus.dcache_wr_ack    = wr_ack;
    assign bus.fill_we          = fill_we;
    assign bus.fill_word        = fill_word;
    assign bus.fill_data        = fill_data;
    assign bus.fill_to_dcache   = to_dcache;
    assign bus.icache_fill_done = i_done;
    assign bus.dcache_fill_done = d_done;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    typedef struct {
        int          kind;      // 0 I-miss, 1 D-miss, 2 store
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_addr;  // expected block base (fills) or write address (store)
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Pipelined memory: read issued in cycle t returns data in cycle t+MEM_LAT.
    logic        pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];
    logic        stray_v = 1'b0;

    always @(posedge clk) begin
        pipe_v[0] <= bus.mem_enable & ~bus.mem_wr;
        pipe_a[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign bus.mem_data_valid = pipe_v[MEM_LAT-1] | stray_v;
    assign bus.mem_data_out   = stray_v ? 16'hDEAD : (pipe_a[MEM_LAT-1] ^ 16'hA5A5);

    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " mem_enable"}, 32'(bus.mem_enable), 0);
        chk({tag, " mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, " mem_data_in"}, 32'(bus.mem_data_in), 0);
        chk({tag, " fill_we"}, 32'(bus.fill_we), 0);
        chk({tag, " fill_word"}, 32'(bus.fill_word), 0);
        chk({tag, " fill_data"}, 32'(bus.fill_data), 0);
        chk({tag, " fill_to_dcache"}, 32'(bus.fill_to_dcache), 0);
        chk({tag, " icache_fill_done"}, 32'(bus.icache_fill_done), 0);
        chk({tag, " dcache_fill_done"}, 32'(bus.dcache_fill_done), 0);
        chk({tag, " dcache_wr_ack"}, 32'(bus.dcache_wr_ack), 0);
    endtask

    // Called just after a negedge with the DUT idle; the request is seen in cycle N.
    task automatic run_fill(input bit is_d, input logic [15:0] addr, input logic [15:0] base);
        logic        exp_en, exp_we;
        logic [15:0] exp_addr, exp_data;
        string       tag;
        if (is_d) begin
            bus.dcache_miss      = 1'b1;
            bus.dcache_miss_addr = addr;
        end else begin
            bus.icache_miss      = 1'b1;
            bus.icache_miss_addr = addr;
        end
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            tag      = $sformatf("%s@%0h N+%0d", is_d ? "dfill" : "ifill", addr, c);
            exp_en   = (c <= 8);
            exp_addr = exp_en ? base + 16'(2 * (c - 1)) : 16'h0;
            exp_we   = (c >= 5) && (c <= 12);
            exp_data = exp_we ? mem_word(base + 16'(2 * (c - 5))) : 16'h0;
            chk({tag, " mem_enable"}, 32'(bus.mem_enable), 32'(exp_en));
            chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
            chk({tag, " mem_wr"}, 32'(bus.mem_wr), 0);
            chk({tag, " fill_we"}, 32'(bus.fill_we), 32'(exp_we));
            if (exp_we) begin
                chk({tag, " fill_word"}, 32'(bus.fill_word), 32'(c - 5));
                chk({tag, " fill_data"}, 32'(bus.fill_data), 32'(exp_data));
                chk({tag, " fill_to_dcache"}, 32'(bus.fill_to_dcache), 32'(is_d));
            end
            chk({tag, " icache_fill_done"}, 32'(bus.icache_fill_done), 32'(!is_d && c == 12));
            chk({tag, " dcache_fill_done"}, 32'(bus.dcache_fill_done), 32'(is_d && c == 12));
            if (c == 12) begin
                bus.icache_miss = 1'b0;
                bus.dcache_miss = 1'b0;
            end
        end
    endtask

    task automatic run_store(input logic [15:0] addr, input logic [15:0] data, input logic [15:0] exp_addr);
        bus.dcache_wr_req  = 1'b1;
        bus.dcache_wr_addr = addr;
        bus.dcache_wr_data = data;
        @(negedge clk);
        chk("store N+1 mem_enable", 32'(bus.mem_enable), 1);
        chk("store N+1 mem_wr", 32'(bus.mem_wr), 1);
        chk("store N+1 mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        chk("store N+1 mem_data_in", 32'(bus.mem_data_in), 32'(data));
        chk("store N+1 dcache_wr_ack", 32'(bus.dcache_wr_ack), 1);
        chk("store N+1 fill_we", 32'(bus.fill_we), 0);
        bus.dcache_wr_req = 1'b0;
        @(negedge clk);
        chk("store N+2 dcache_wr_ack", 32'(bus.dcache_wr_ack), 0);
        chk("store N+2 mem_enable", 32'(bus.mem_enable), 0);
    endtask

    vec_t vecs [6];

    initial begin
        int          n;
        logic [31:0] ord;
        bit          found;

        vecs[0] = '{kind: 1, addr: 16'hFFF8, data: 16'h0000, exp_addr: 16'hFFF0};
        vecs[1] = '{kind: 2, addr: 16'h0040, data: 16'hBEEF, exp_addr: 16'h0040};
        vecs[2] = '{kind: 1, addr: 16'h8001, data: 16'h0000, exp_addr: 16'h8000};
        vecs[3] = '{kind: 2, addr: 16'h7FFE, data: 16'h1357, exp_addr: 16'h7FFE};
        vecs[4] = '{kind: 0, addr: 16'h000F, data: 16'h0000, exp_addr: 16'h0000};
        vecs[5] = '{kind: 0, addr: 16'h1236, data: 16'h0000, exp_addr: 16'h1230};

        bus.icache_miss      = 1'b0;
        bus.icache_miss_addr = 16'h0;
        bus.dcache_miss      = 1'b0;
        bus.dcache_miss_addr = 16'h0;
        bus.dcache_wr_req    = 1'b0;
        bus.dcache_wr_addr   = 16'h0;
        bus.dcache_wr_data   = 16'h0;

        // Reset held for 3 cycles, then idle with no requests.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("idle c%0d mem_enable", c), 32'(bus.mem_enable), 0);
            chk($sformatf("idle c%0d fill_we", c), 32'(bus.fill_we), 0);
        end

        for (int i = 0; i < 6; i++) begin
            case (vecs[i].kind)
                0:       run_fill(1'b0, vecs[i].addr, vecs[i].exp_addr);
                1:       run_fill(1'b1, vecs[i].addr, vecs[i].exp_addr);
                default: run_store(vecs[i].addr, vecs[i].data, vecs[i].exp_addr);
            endcase
        end

        // All three requests at once, the previous fill having gone to the I-cache.
        bus.dcache_wr_req    = 1'b1;
        bus.dcache_wr_addr   = 16'h0100;
        bus.dcache_wr_data   = 16'h1234;
        bus.dcache_miss      = 1'b1;
        bus.dcache_miss_addr = 16'h2000;
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h3000;
        n   = 0;
        ord = 32'h0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (bus.fill_we) begin
                chk($sformatf("combined c%0d fill_to_dcache", c), 32'(bus.fill_to_dcache), 32'(n == 1));
            end
            if (bus.dcache_wr_ack) begin
                ord = {ord[23:0], 8'h57};
                bus.dcache_wr_req = 1'b0;
                n++;
            end
            if (bus.dcache_fill_done) begin
                ord = {ord[23:0], 8'h44};
                bus.dcache_miss = 1'b0;
                n++;
            end
            if (bus.icache_fill_done) begin
                ord = {ord[23:0], 8'h49};
                bus.icache_miss = 1'b0;
                n++;
            end
        end
        chk("combined event count", 32'(n), 3);
        chk("combined order WDI", ord, 32'h00574449);
        bus.dcache_wr_req = 1'b0;
        bus.dcache_miss   = 1'b0;
        bus.icache_miss   = 1'b0;
        @(negedge clk);
        chk("combined idle mem_enable", 32'(bus.mem_enable), 0);

        // Reset in the middle of a fill, at word 3.
        bus.icache_miss      = 1'b1;
        bus.icache_miss_addr = 16'h4444;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.fill_we && bus.fill_word == 3'd3) found = 1'b1;
        end
        chk("midfill word3 reached", 32'(found), 1);
        #1;
        rst = 1'b1;
        bus.icache_miss = 1'b0;
        #1;
        check_all_zero("midfill reset");
        repeat (2) @(negedge clk);
        check_all_zero("midfill reset held");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset c%0d fill_we", c), 32'(bus.fill_we), 0);
            chk($sformatf("post-reset c%0d mem_enable", c), 32'(bus.mem_enable), 0);
        end
        run_fill(1'b1, 16'h5678, 16'h5670);

        // Stray return while idle.
        stray_v = 1'b1;
        #1;
        chk("stray fill_we", 32'(bus.fill_we), 0);
        chk("stray icache_fill_done", 32'(bus.icache_fill_done), 0);
        chk("stray dcache_fill_done", 32'(bus.dcache_fill_done), 0);
        @(negedge clk);
        chk("stray held fill_we", 32'(bus.fill_we), 0);
        chk("stray held mem_enable", 32'(bus.mem_enable), 0);
        stray_v = 1'b0;
        run_fill(1'b0, 16'h0ABC, 16'h0AB0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
